// File: rtl/score_display_ctrl.sv
// Round timer and order tracker with a multiplexed four-digit score display.
// A free-running shift-add-3 engine converts the saturated score to BCD for the scan logic.

module score_display_ctrl #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned SCAN_DIV   = 25_000,
  parameter int unsigned ROUND_TIME = 60
) (
  input  logic        basys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  order_pulse,
  output logic [15:0] time_left,
  output logic [2:0]  orders_done,
  output logic        round_over,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [15:0]       ROUND_LOAD = 16'(ROUND_TIME);
  localparam logic [16:0]       SCORE_MAX  = 17'd9999;
  localparam logic [4:0]        CONV_LAST  = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [15:0]        time_q, time_d;
  logic [2:0]         orders_q, orders_d;
  logic               over_q, over_d;

  logic [1:0]         done_count;
  logic [16:0]        score_raw;
  logic [13:0]        score;

  logic [4:0]         conv_cnt_q, conv_cnt_d;
  logic [15:0]        bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [15:0]        bcd_adj;
  logic [15:0]        digits_q, digits_d;

  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         digit;
  logic [3:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;

  // Both the tick decrement and the order merge land before the OVER test,
  // so a simultaneous timeout and final order are both recorded.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    time_d   = time_q;
    orders_d = orders_q;
    unique case (state_q)
      IDLE: begin
        time_d   = ROUND_LOAD;
        orders_d = 3'b000;
        tick_d   = '0;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        orders_d = orders_q | order_pulse;
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (time_q != 16'd0) begin
            time_d = time_q - 16'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
        if ((time_d == 16'd0) || (orders_d == 3'b111)) begin
          state_d = OVER;
        end
      end
      OVER: begin
        if (start) begin
          state_d  = RUN;
          time_d   = ROUND_LOAD;
          orders_d = 3'b000;
          tick_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    over_d = (state_d == OVER);
  end

  always_ff @(posedge basys_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      time_q   <= ROUND_LOAD;
      orders_q <= 3'b000;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      time_q   <= time_d;
      orders_q <= orders_d;
      over_q   <= over_d;
    end
  end

  assign time_left   = time_q;
  assign orders_done = orders_q;
  assign round_over  = over_q;

  always_comb begin
    done_count = 2'(orders_q[0]) + 2'(orders_q[1]) + 2'(orders_q[2]);
    score_raw  = 17'(done_count) * 17'd1000 + 17'(time_q);
    score      = (score_raw > SCORE_MAX) ? 14'd9999 : score_raw[13:0];
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Count 0 snapshots the score; counts 1..16 each adjust and shift one bit.
  // The digit registers only take the finished result on the last shift.
  always_comb begin
    conv_cnt_d = conv_cnt_q + 5'd1;
    bin_d      = {bin_q[14:0], 1'b0};
    bcd_d      = {bcd_adj[14:0], bin_q[15]};
    digits_d   = digits_q;
    if (conv_cnt_q == 5'd0) begin
      bin_d = {2'b00, score};
      bcd_d = 16'd0;
    end else if (conv_cnt_q == CONV_LAST) begin
      digits_d   = bcd_d;
      conv_cnt_d = 5'd0;
    end
  end

  always_ff @(posedge basys_clk) begin
    if (rst) begin
      conv_cnt_q <= 5'd0;
      bin_q      <= 16'd0;
      bcd_q      <= 16'd0;
      digits_q   <= 16'd0;
    end else begin
      conv_cnt_q <= conv_cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      digits_q   <= digits_d;
    end
  end

  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = sel_q + 2'd1;
    end
  end

  // Segment pattern and anode enable derive from the same select value and
  // register together, so a digit never appears under the wrong enable.
  always_comb begin
    digit = 4'd0;
    an_d  = 4'b1111;
    unique case (sel_q)
      2'd0: begin digit = digits_q[3:0];   an_d = 4'b1110; end
      2'd1: begin digit = digits_q[7:4];   an_d = 4'b1101; end
      2'd2: begin digit = digits_q[11:8];  an_d = 4'b1011; end
      2'd3: begin digit = digits_q[15:12]; an_d = 4'b0111; end
      default: begin digit = 4'd0; an_d = 4'b1111; end
    endcase
    seg_d = 8'hFF;
    unique case (digit)
      4'd0: seg_d = 8'hC0;
      4'd1: seg_d = 8'hF9;
      4'd2: seg_d = 8'hA4;
      4'd3: seg_d = 8'hB0;
      4'd4: seg_d = 8'h99;
      4'd5: seg_d = 8'h92;
      4'd6: seg_d = 8'h82;
      4'd7: seg_d = 8'hF8;
      4'd8: seg_d = 8'h80;
      4'd9: seg_d = 8'h90;
      default: seg_d = 8'hFF;
    endcase
  end

  always_ff @(posedge basys_clk) begin
    if (rst) begin
      scan_q <= '0;
      sel_q  <= 2'd0;
      an_q   <= 4'b1110;
      seg_q  <= 8'hC0;
    end else begin
      scan_q <= scan_d;
      sel_q  <= sel_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: directed round scenarios plus random
// order/start/reset traffic, all compared against a cycle-level behavioural model.

module tb_score_display_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int SCAN_DIV   = 2;
  localparam int ROUND_TIME = 5;
  localparam int BIG_TIME   = 9000;

  logic        basysClk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [2:0]  orderPulse = 3'b000;
  logic [2:0]  orderPulse2 = 3'b000;

  logic [15:0] timeLeft, timeLeft2;
  logic [2:0]  ordersDone, ordersDone2;
  logic        roundOver, roundOver2;
  logic [7:0]  seg, seg2;
  logic [3:0]  an, an2;

  int total = 0;
  int bad = 0;

  // Behavioural model: 0 = idle, 1 = running, 2 = over
  int mState;
  int mTime;
  int mOrders;
  int mToTick;

  logic [3:0] anCodes [4];
  logic [3:0] anHist [20];
  int edgeAt;
  int baseIdx;

  always #5 basysClk = ~basysClk;

  score_display_ctrl #(
    .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .ROUND_TIME(ROUND_TIME)
  ) dut (
    .basys_clk(basysClk), .rst(rst), .start(start), .order_pulse(orderPulse),
    .time_left(timeLeft), .orders_done(ordersDone), .round_over(roundOver),
    .seg(seg), .an(an)
  );

  score_display_ctrl #(
    .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .ROUND_TIME(BIG_TIME)
  ) dutBig (
    .basys_clk(basysClk), .rst(rst), .start(start2), .order_pulse(orderPulse2),
    .time_left(timeLeft2), .orders_done(ordersDone2), .round_over(roundOver2),
    .seg(seg2), .an(an2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input logic r, input logic s, input logic [2:0] op);
    if (r) begin
      mState = 0; mTime = ROUND_TIME; mOrders = 0; mToTick = TICK_DIV;
    end else if (mState == 0) begin
      if (s) begin mState = 1; mToTick = TICK_DIV; end
    end else if (mState == 1) begin
      mToTick = mToTick - 1;
      if (mToTick == 0) begin
        mTime = mTime - 1;
        mToTick = TICK_DIV;
      end
      mOrders = mOrders | int'(op);
      if (mTime == 0 || mOrders == 7) mState = 2;
    end else begin
      if (s) begin
        mState = 1; mTime = ROUND_TIME; mOrders = 0; mToTick = TICK_DIV;
      end
    end
  endtask

  function automatic int modelScore();
    int v;
    v = $countones(mOrders) * 1000 + mTime;
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [7:0] segFor(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic applyStimulus(input logic r, input logic s, input logic [2:0] op);
    rst = r;
    start = s;
    orderPulse = op;
    @(posedge basysClk);
    modelStep(r, s, op);
    #1;
    checkOutput("time_left", 32'(timeLeft), mTime);
    checkOutput("orders_done", 32'(ordersDone), mOrders);
    checkOutput("round_over", 32'(roundOver), 32'(mState == 2));
  endtask

  // Let the converter settle, then capture one full scan and compare each digit.
  task automatic checkDisplay(input int which, input int score, input string tag);
    logic [7:0] shown [4];
    logic [3:0] a;
    logic [7:0] sg;
    int p;
    for (int d = 0; d < 4; d++) shown[d] = 8'h00;
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000);
      a  = (which != 0) ? an2 : an;
      sg = (which != 0) ? seg2 : seg;
      case (a)
        4'b1110: shown[0] = sg;
        4'b1101: shown[1] = sg;
        4'b1011: shown[2] = sg;
        4'b0111: shown[3] = sg;
        default: ;
      endcase
    end
    p = 1;
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("%s_digit%0d", tag, d), 32'(shown[d]), 32'(segFor((score / p) % 10)));
      p = p * 10;
    end
  endtask

  initial begin
    int budget;
    logic s;
    logic r;
    logic [2:0] op;

    anCodes[0] = 4'b1110; anCodes[1] = 4'b1101;
    anCodes[2] = 4'b1011; anCodes[3] = 4'b0111;

    // Reset and the first post-reset display state
    applyStimulus(1'b1, 1'b0, 3'b000);
    checkOutput("reset_an", 32'(an), 32'(4'b1110));
    checkOutput("reset_seg", 32'(seg), 32'(8'hC0));

    // Scan rotation: after the first change, each enable holds for two cycles
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000);
      anHist[i] = an;
    end
    edgeAt = -1;
    for (int i = 1; i < 20; i++)
      if (edgeAt < 0 && anHist[i] !== anHist[i-1]) edgeAt = i;
    checkOutput("scan_edge_found", 32'(edgeAt > 0 && edgeAt <= 4), 1);
    if (edgeAt > 0 && edgeAt <= 4) begin
      baseIdx = -1;
      for (int b = 0; b < 4; b++) if (anCodes[b] === anHist[edgeAt]) baseIdx = b;
      checkOutput("scan_code_legal", 32'(baseIdx >= 0), 1);
      if (baseIdx >= 0) begin
        checkOutput("scan_prev_code", 32'(anHist[edgeAt-1]), 32'(anCodes[(baseIdx + 3) % 4]));
        for (int k = 0; k < 14; k++)
          checkOutput("scan_seq", 32'(anHist[edgeAt+k]), 32'(anCodes[(baseIdx + k/2) % 4]));
      end
    end
    checkDisplay(0, 5, "idle");

    // Plain countdown to timeout
    applyStimulus(1'b0, 1'b1, 3'b000);
    budget = 40;
    while (mState != 2 && budget > 0) begin
      applyStimulus(1'b0, 1'b0, 3'b000);
      budget--;
    end
    checkOutput("countdown_in_budget", 32'(budget > 0), 1);
    checkOutput("countdown_over", 32'(roundOver), 1);
    checkOutput("countdown_time", 32'(timeLeft), 0);
    checkDisplay(0, 0, "timeout");

    // Start in OVER restarts the round, start in RUN is ignored, reset mid-run
    applyStimulus(1'b0, 1'b1, 3'b000);
    checkOutput("restart_time", 32'(timeLeft), 5);
    checkOutput("restart_over", 32'(roundOver), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 3'b000);
    checkOutput("start_in_run_time", 32'(timeLeft), 4);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 3'b000);
    applyStimulus(1'b1, 1'b0, 3'b010);
    checkOutput("midrun_rst_time", 32'(timeLeft), 5);
    checkOutput("midrun_rst_orders", 32'(ordersDone), 0);
    checkOutput("midrun_rst_over", 32'(roundOver), 0);

    // All orders completed before the clock runs out
    applyStimulus(1'b0, 1'b1, 3'b000);
    budget = 30;
    while (mTime != 3 && budget > 0) begin applyStimulus(1'b0, 1'b0, 3'b000); budget--; end
    applyStimulus(1'b0, 1'b0, 3'b101);
    budget = 30;
    while (mTime != 2 && budget > 0) begin applyStimulus(1'b0, 1'b0, 3'b000); budget--; end
    applyStimulus(1'b0, 1'b0, 3'b010);
    checkOutput("orders_over", 32'(roundOver), 1);
    checkOutput("orders_time", 32'(timeLeft), 2);
    checkOutput("orders_done_all", 32'(ordersDone), 7);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    checkDisplay(0, 3002, "orders");

    // Final tick and an order on the same cycle
    applyStimulus(1'b0, 1'b1, 3'b000);
    budget = 40;
    while (!(mTime == 1 && mToTick == 1) && budget > 0) begin
      applyStimulus(1'b0, 1'b0, 3'b000);
      budget--;
    end
    checkOutput("same_cycle_in_budget", 32'(budget > 0), 1);
    applyStimulus(1'b0, 1'b0, 3'b001);
    checkOutput("same_cycle_over", 32'(roundOver), 1);
    checkOutput("same_cycle_time", 32'(timeLeft), 0);
    checkOutput("same_cycle_orders", 32'(ordersDone), 1);
    checkDisplay(0, 1000, "same_cycle");

    // Saturation on the long-round instance
    start2 = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000);
    start2 = 1'b0;
    orderPulse2 = 3'b111;
    applyStimulus(1'b0, 1'b0, 3'b000);
    orderPulse2 = 3'b000;
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("big_time", 32'(timeLeft2), BIG_TIME);
    checkOutput("big_over", 32'(roundOver2), 1);
    checkOutput("big_orders", 32'(ordersDone2), 7);
    checkDisplay(1, 9999, "saturate");

    // Random rounds with sparse orders, stray starts and occasional reset
    for (int round = 0; round < 8; round++) begin
      applyStimulus(1'b0, 1'b1, 3'b000);
      for (int c = 0; c < 80 && mState == 1; c++) begin
        op = ($urandom_range(0, 5) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
        s  = ($urandom_range(0, 15) == 0);
        r  = ($urandom_range(0, 59) == 0);
        applyStimulus(r, s, op);
      end
      if (mState != 1) checkDisplay(0, modelScore(), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- TICK_DIV, 100_000_000, basys_clk cycles per 1 s game tick.
- SCAN_DIV, 25_000, basys_clk cycles per digit-scan step.
- ROUND_TIME, 60, seconds loaded into time_left at round start; legal range 1..9999.
REQ-002 Ports, one per line (name, direction, width, meaning):
- basys_clk, in, 1, the single clock for all logic.
- rst, in, 1, reset; synchronous, active-high.
- start, in, 1, single-cycle pulse that begins a round.
- order_pulse, in, 3, per-order completion pulses; bit i marks order i done.
- time_left, out, 16, seconds remaining.
- orders_done, out, 3, sticky done flags, one bit per order.
- round_over, out, 1, high while the FSM is in OVER.
- seg, out, 8, active-low segments {dp,g..a}; dp is always 1.
- an, out, 4, active-low digit enables.

Function
REQ-003 FSM states are IDLE, RUN and OVER; all outputs are registered.
REQ-004 IDLE:
- time_left=ROUND_TIME and orders_done=0 are held.
- start moves the FSM to RUN and clears the tick prescaler.
REQ-005 RUN, prescaler:
- Counts 0..TICK_DIV-1.
- On terminal count, time_left decrements by 1.
REQ-006 RUN, orders: orders_done <= orders_done | order_pulse every cycle.
REQ-007 RUN to OVER:
- Taken on the cycle time_left becomes 0, or on the cycle orders_done becomes 3'b111, whichever happens first.
- If both occur in the same cycle, the tick decrement and the order update both take effect.
REQ-008 RUN, ignored input: start is ignored.
REQ-009 OVER:
- time_left and orders_done are frozen; order_pulse is ignored.
- start reloads time_left=ROUND_TIME, clears orders_done and the prescaler, and enters RUN directly.
REQ-010 Score = popcount(orders_done)*1000 + time_left.
- Computed in 17 bits, then saturated to 9999.
REQ-011 Binary-to-BCD conversion is sequential (shift-add-3):
- 1 load cycle plus 16 shift cycles.
- Each conversion snapshots the current score at load.
- A new conversion starts on the cycle after the previous one finishes, free-running.
REQ-012 The four displayed digit registers update atomically only when a conversion completes; no partially converted value is ever displayed.
REQ-013 A score change is visible on the digit registers within 34 basys_clk cycles.
REQ-014 Scan counter:
- Counts 0..SCAN_DIV-1.
- On terminal count, digit_select (2 bits) increments and wraps 3 to 0.
REQ-015 an per digit_select value:
- 0 gives 1110 (ones).
- 1 gives 1101 (tens).
- 2 gives 1011 (hundreds).
- 3 gives 0111 (thousands).
REQ-016 seg codes for digits 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
- Leading zeros are displayed.
- A non-BCD digit value drives FF (blank).
REQ-017 seg and an register on the same edge, so a digit and its enable never mismatch.
REQ-018 round_over is 1 exactly when state==OVER.

Reset
REQ-019 rst has priority over all other inputs.
- It takes effect on the next basys_clk edge, including mid-RUN and mid-conversion.
REQ-020 Values after reset:
- state=IDLE, time_left=ROUND_TIME, orders_done=0, round_over=0.
- Both prescalers=0, digit_select=0, converter restarts from load.
- Digit registers=0, an=1110, seg=C0.

Verification (bench parameters TICK_DIV=4, SCAN_DIV=2, ROUND_TIME=5 unless stated)
REQ-021 Reset, then idle for 40 cycles:
- an=1110 and seg=C0 on the first cycle after reset.
- Display settles to 0005 and time_left=5.
- an cycles 1110, 1101, 1011, 0111 every 2 cycles.
REQ-022 start with no orders:
- time_left steps 5, 4, 3, 2, 1, 0, one step every 4 cycles.
- round_over rises on the cycle time_left=0.
- Display settles to 0000.
REQ-023 During RUN, set order_pulse=101 at time_left=3, then 010 at time_left=2:
- OVER is entered with time_left=2 and orders_done=111; display reads 3002.
- Further ticks and pulses change nothing.
REQ-024 order_pulse=001 on the same cycle as the tick taking time_left 1 to 0:
- OVER with time_left=0 and orders_done=001; display reads 1000.
REQ-025 With ROUND_TIME=9000, pulse start then order_pulse=111:
- OVER with time_left=9000.
- Display reads 9999 (saturated from 12000).
REQ-026 Control edge cases:
- start pulsed during RUN is ignored (time_left is unaffected).
- rst asserted mid-RUN gives IDLE, time_left=5, orders_done=0 on the next edge.
- start in OVER enters RUN with time_left=5.
